// File: rtl/ocp3_nic_pkg.sv
// Shared types for the OCP3 NIC power monitor: FSM encodings, fault codes, widths.
package ocp3_nic_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned TIMER_W = 16;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF       = 3'd0,
    ST_AUX_WAIT  = 3'd1,
    ST_AUX_ON    = 3'd2,
    ST_MAIN_WAIT = 3'd3,
    ST_MAIN_ON   = 3'd4,
    ST_FAULT     = 3'd5
  } mon_state_e;

  typedef enum logic [CODE_W-1:0] {
    FC_NONE      = 3'd0,
    FC_AUX_TMO   = 3'd1,
    FC_AUX_DROP  = 3'd2,
    FC_MAIN_TMO  = 3'd3,
    FC_MAIN_DROP = 3'd4,
    FC_SURPRISE  = 3'd5,
    FC_ORDER     = 3'd6
  } fault_code_e;

endpackage

// File: rtl/pg_sync_filter.sv
// Pin synchronizer with an optional drop filter: rises pass straight through, a
// drop is declared only after PG_FILT_CYC consecutive low synchronized samples.
module pg_sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PG_FILT_CYC = 4,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iPin,
  output logic oLevel,
  output logic oDrop
);

  logic [SYNC_STAGES-1:0] syncQ;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) syncQ <= {SYNC_STAGES{RST_VAL}};
    else         syncQ <= {syncQ[SYNC_STAGES-2:0], iPin};
  end

  assign oLevel = syncQ[SYNC_STAGES-1];

  generate
    if (PG_FILT_CYC == 0) begin : gNoFilt
      assign oDrop = ~oLevel;
    end else begin : gFilt
      localparam int unsigned FCNT_W = $clog2(PG_FILT_CYC + 1);
      logic [FCNT_W-1:0] lowCnt;

      // Consecutive-low counter; any high sample restarts it.
      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)                               lowCnt <= '0;
        else if (oLevel)                           lowCnt <= '0;
        else if (lowCnt != FCNT_W'(PG_FILT_CYC))   lowCnt <= lowCnt + FCNT_W'(1);
      end

      assign oDrop = (lowCnt == FCNT_W'(PG_FILT_CYC));
    end
  endgenerate

endmodule

// File: rtl/ocp3_nic_pwr_monitor.sv
// OCP3 NIC rail fault monitor: watches sequencer enables against power-good and
// presence, latches a fault code, requests force-off and counts fault entries.
module ocp3_nic_pwr_monitor
  import ocp3_nic_pkg::*;
#(
  parameter int unsigned AUX_TMO_MS  = 50,
  parameter int unsigned MAIN_TMO_MS = 100,
  parameter int unsigned PG_FILT_CYC = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iTick_1ms,
  input  logic               iPRSNT_NIC_N,
  input  logic               iPWRGD_NIC_EDGE,
  input  logic               iPWRGD_NIC_PWR_GOOD,
  input  logic               iNIC_AUX_PWR_EN,
  input  logic               iNIC_MAIN_PWR_EN,
  input  logic               iFAULT_CLR,
  output logic               oNIC_FAULT,
  output logic               oFORCE_OFF,
  output logic [CODE_W-1:0]  oFAULT_CODE,
  output logic [CNT_W-1:0]   oFAULT_CNT,
  output logic [STATE_W-1:0] oDBG_MON_FSM
);

  logic auxPg, auxDrop, mainPg, mainDrop, nicAbsent, unusedPrsntLow;

  pg_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .PG_FILT_CYC(PG_FILT_CYC), .RST_VAL(1'b0)) uAuxPg (
    .iClk(iClk), .iRst_n(iRst_n), .iPin(iPWRGD_NIC_EDGE), .oLevel(auxPg), .oDrop(auxDrop));

  pg_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .PG_FILT_CYC(PG_FILT_CYC), .RST_VAL(1'b0)) uMainPg (
    .iClk(iClk), .iRst_n(iRst_n), .iPin(iPWRGD_NIC_PWR_GOOD), .oLevel(mainPg), .oDrop(mainDrop));

  // Presence is level-qualified only; reset value reads as absent.
  pg_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .PG_FILT_CYC(0), .RST_VAL(1'b1)) uPrsnt (
    .iClk(iClk), .iRst_n(iRst_n), .iPin(iPRSNT_NIC_N), .oLevel(nicAbsent), .oDrop(unusedPrsntLow));

  mon_state_e          state, stateNext;
  fault_code_e         faultCode, codeNext;
  logic [TIMER_W-1:0]  timer;
  logic [CNT_W-1:0]    faultCnt;
  logic                faultQ;
  logic                orderErr, inWait, timeout;

  assign orderErr = iNIC_MAIN_PWR_EN & ~iNIC_AUX_PWR_EN;
  assign inWait   = (state == ST_AUX_WAIT) || (state == ST_MAIN_WAIT);
  assign timeout  = ((state == ST_AUX_WAIT)  && (timer >= TIMER_W'(AUX_TMO_MS))) ||
                    ((state == ST_MAIN_WAIT) && (timer >= TIMER_W'(MAIN_TMO_MS)));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= ST_OFF;
    else         state <= stateNext;
  end

  // Priority: presence > order > enable deassert > drop > timeout > progress.
  always_comb begin
    stateNext = state;
    codeNext  = faultCode;
    case (state)
      ST_OFF: begin
        if (orderErr) begin
          stateNext = ST_FAULT;
          codeNext  = FC_ORDER;
        end else if (iNIC_AUX_PWR_EN) begin
          stateNext = ST_AUX_WAIT;
        end
      end
      ST_AUX_WAIT, ST_AUX_ON, ST_MAIN_WAIT, ST_MAIN_ON: begin
        if (nicAbsent) begin
          stateNext = ST_FAULT;
          codeNext  = FC_SURPRISE;
        end else if (orderErr) begin
          stateNext = ST_FAULT;
          codeNext  = FC_ORDER;
        end else if (!iNIC_AUX_PWR_EN) begin
          stateNext = ST_OFF;
        end else begin
          case (state)
            ST_AUX_WAIT: begin
              if (timeout) begin
                stateNext = ST_FAULT;
                codeNext  = FC_AUX_TMO;
              end else if (auxPg) begin
                stateNext = ST_AUX_ON;
              end
            end
            ST_AUX_ON: begin
              if (auxDrop) begin
                stateNext = ST_FAULT;
                codeNext  = FC_AUX_DROP;
              end else if (iNIC_MAIN_PWR_EN) begin
                stateNext = ST_MAIN_WAIT;
              end
            end
            ST_MAIN_WAIT: begin
              if (!iNIC_MAIN_PWR_EN) begin
                stateNext = ST_AUX_ON;
              end else if (auxDrop) begin
                stateNext = ST_FAULT;
                codeNext  = FC_AUX_DROP;
              end else if (timeout) begin
                stateNext = ST_FAULT;
                codeNext  = FC_MAIN_TMO;
              end else if (mainPg) begin
                stateNext = ST_MAIN_ON;
              end
            end
            ST_MAIN_ON: begin
              if (!iNIC_MAIN_PWR_EN) begin
                stateNext = ST_AUX_ON;
              end else if (auxDrop) begin
                stateNext = ST_FAULT;
                codeNext  = FC_AUX_DROP;
              end else if (mainDrop) begin
                stateNext = ST_FAULT;
                codeNext  = FC_MAIN_DROP;
              end
            end
            default: ;
          endcase
        end
      end
      ST_FAULT: begin
        if (iFAULT_CLR && !iNIC_AUX_PWR_EN && !iNIC_MAIN_PWR_EN) begin
          stateNext = ST_OFF;
          codeNext  = FC_NONE;
        end
      end
      default: begin
        stateNext = ST_OFF;
        codeNext  = FC_NONE;
      end
    endcase
  end

  // Timer, fault record and registered flags, all aligned with the state register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      timer     <= '0;
      faultCode <= FC_NONE;
      faultCnt  <= '0;
      faultQ    <= 1'b0;
    end else begin
      if (stateNext != state)                          timer <= '0;
      else if (iTick_1ms && inWait && (timer != '1))   timer <= timer + TIMER_W'(1);
      faultCode <= codeNext;
      if ((stateNext == ST_FAULT) && (state != ST_FAULT) && (faultCnt != '1))
        faultCnt <= faultCnt + CNT_W'(1);
      faultQ <= (stateNext == ST_FAULT);
    end
  end

  assign oNIC_FAULT   = faultQ;
  assign oFORCE_OFF   = faultQ;
  assign oFAULT_CODE  = faultCode;
  assign oFAULT_CNT   = faultCnt;
  assign oDBG_MON_FSM = state;

endmodule
